// File: rtl/logic_muxn_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : logic_muxn_scan_if
// Description : Control, data and status bundle for the scanning N:1 mux.
// Revision    : 1.0 - initial release
// ============================================================================
interface logic_muxn_scan_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic                      en;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [CHANNELS*WIDTH-1:0] din;
    logic [WIDTH-1:0]          y;
    logic                      y_valid;
    logic [SEL_W-1:0]          ch_out;
    logic                      wrap;
    logic                      sel_err;

    modport master (
        output en, mode, sel, din,
        input  y, y_valid, ch_out, wrap, sel_err
    );

    modport slave (
        input  en, mode, sel, din,
        output y, y_valid, ch_out, wrap, sel_err
    );
endinterface
`default_nettype wire

// File: rtl/logic_muxn_scan.sv
`default_nettype none
// ============================================================================
// Module      : logic_muxn_scan
// Description : Registered N-channel mux with manual select and auto-scan.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_muxn_scan #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 4
) (
    input wire logic            clk,
    input wire logic            rst,
    logic_muxn_scan_if.slave    bus
);
    localparam int               SEL_W        = $clog2(CHANNELS);
    localparam logic [SEL_W-1:0] c_CH_LAST    = SEL_W'(CHANNELS - 1);
    localparam logic [7:0]       c_DWELL_LAST = 8'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_y;
    logic             r_y_valid;
    logic [SEL_W-1:0] r_ch_out;
    logic             r_wrap;
    logic             r_sel_err;
    logic [SEL_W-1:0] r_scan_ch;
    logic [7:0]       r_dwell_cnt;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_y_nxt;
    logic             w_y_valid_nxt;
    logic [SEL_W-1:0] w_ch_out_nxt;
    logic             w_wrap_nxt;
    logic             w_sel_err_nxt;
    logic [SEL_W-1:0] w_scan_ch_nxt;
    logic [7:0]       w_dwell_nxt;
    logic             w_sel_ok;

    function automatic logic [WIDTH-1:0] f_pick(
        input logic [CHANNELS*WIDTH-1:0] d,
        input logic [SEL_W-1:0]          idx
    );
        f_pick = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_W'(k)) f_pick = d[k*WIDTH +: WIDTH];
        end
    endfunction

    assign w_sel_ok = ({{(32-SEL_W){1'b0}}, bus.sel} < 32'(CHANNELS));

    // The mode input picks this edge's action directly, so leaving IDLE or
    // switching modes loads the new source on the same edge.
    always_comb begin
        w_state_nxt   = r_state;
        w_y_nxt       = r_y;
        w_y_valid_nxt = r_y_valid;
        w_ch_out_nxt  = r_ch_out;
        w_wrap_nxt    = 1'b0;
        w_sel_err_nxt = r_sel_err;
        w_scan_ch_nxt = r_scan_ch;
        w_dwell_nxt   = r_dwell_cnt;

        if (bus.en) begin
            if (bus.mode) begin
                w_state_nxt   = ST_SCAN;
                w_y_valid_nxt = 1'b1;
                if (r_state != ST_SCAN) begin
                    w_scan_ch_nxt = '0;
                    w_dwell_nxt   = '0;
                end else if (r_dwell_cnt == c_DWELL_LAST) begin
                    w_dwell_nxt = '0;
                    if (r_scan_ch == c_CH_LAST) begin
                        w_scan_ch_nxt = '0;
                        w_wrap_nxt    = 1'b1;
                    end else begin
                        w_scan_ch_nxt = r_scan_ch + 1'b1;
                    end
                end else begin
                    w_dwell_nxt = r_dwell_cnt + 8'd1;
                end
                // Output tracks the post-edge scan position, so a channel is
                // visible for exactly DWELL cycles.
                w_y_nxt      = f_pick(bus.din, w_scan_ch_nxt);
                w_ch_out_nxt = w_scan_ch_nxt;
            end else begin
                w_state_nxt   = ST_MANUAL;
                w_scan_ch_nxt = '0;
                w_dwell_nxt   = '0;
                if (w_sel_ok) begin
                    w_y_nxt       = f_pick(bus.din, bus.sel);
                    w_ch_out_nxt  = bus.sel;
                    w_y_valid_nxt = 1'b1;
                    w_sel_err_nxt = 1'b0;
                end else begin
                    w_y_valid_nxt = 1'b0;
                    w_sel_err_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_y         <= '0;
            r_y_valid   <= 1'b0;
            r_ch_out    <= '0;
            r_wrap      <= 1'b0;
            r_sel_err   <= 1'b0;
            r_scan_ch   <= '0;
            r_dwell_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_y         <= w_y_nxt;
            r_y_valid   <= w_y_valid_nxt;
            r_ch_out    <= w_ch_out_nxt;
            r_wrap      <= w_wrap_nxt;
            r_sel_err   <= w_sel_err_nxt;
            r_scan_ch   <= w_scan_ch_nxt;
            r_dwell_cnt <= w_dwell_nxt;
        end
    end

    assign bus.y       = r_y;
    assign bus.y_valid = r_y_valid;
    assign bus.ch_out  = r_ch_out;
    assign bus.wrap    = r_wrap;
    assign bus.sel_err = r_sel_err;
endmodule
`default_nettype wire
